lane_level_sequencer: RTL and testbench

//  Game-level controller for the vehicle lanes. Sequences start, level-up, life loss, win and game-over.

---
 rtl/lane_level_sequencer_if.sv | 28 ++
 rtl/lane_level_sequencer.sv | 126 ++++++++++++
 tb/tb_lane_level_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/lane_level_sequencer_if.sv
// Connects the level sequencer to the frog/collision logic and to the lane registers.
// The frog/collision side drives the event pulses; the sequencer drives level, strobe and status.
interface lane_level_sequencer_if #(
    parameter int DATAWIDTH_NIVEL = 2,
    parameter int LIVES_WIDTH     = 2
);
    logic                       LVLSEQ_START_IN;
    logic                       LVLSEQ_GOAL_IN;
    logic                       LVLSEQ_COLLISION_IN;
    logic [DATAWIDTH_NIVEL-1:0] LVLSEQ_NVL_OUT;
    logic                       LVLSEQ_CN_OUT;
    logic [LIVES_WIDTH-1:0]     LVLSEQ_LIVES_OUT;
    logic                       LVLSEQ_WIN_OUT;
    logic                       LVLSEQ_GAMEOVER_OUT;
    logic [2:0]                 LVLSEQ_STATE_OUT;

    modport master (
        output LVLSEQ_START_IN, LVLSEQ_GOAL_IN, LVLSEQ_COLLISION_IN,
        input  LVLSEQ_NVL_OUT, LVLSEQ_CN_OUT, LVLSEQ_LIVES_OUT,
               LVLSEQ_WIN_OUT, LVLSEQ_GAMEOVER_OUT, LVLSEQ_STATE_OUT
    );

    modport slave (
        input  LVLSEQ_START_IN, LVLSEQ_GOAL_IN, LVLSEQ_COLLISION_IN,
        output LVLSEQ_NVL_OUT, LVLSEQ_CN_OUT, LVLSEQ_LIVES_OUT,
               LVLSEQ_WIN_OUT, LVLSEQ_GAMEOVER_OUT, LVLSEQ_STATE_OUT
    );
endinterface

// File: rtl/lane_level_sequencer.sv
// Game-level controller: sequences start, level-up, life loss, win and game-over,
// and drives the shared level code plus level-change strobe to the lane registers.
module lane_level_sequencer #(
    parameter int DATAWIDTH_NIVEL = 2,
    parameter int MAX_LEVEL       = 3,
    parameter int NUM_LIVES       = 3,
    parameter int LIVES_WIDTH     = 2,
    parameter int HOLD_CYCLES     = 8,
    parameter int HOLD_WIDTH      = 4
) (
    input  logic                  LVLSEQ_CLOCK,
    input  logic                  LVLSEQ_RESET,
    lane_level_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_HOLD = 3'd3,
        ST_WIN  = 3'd4,
        ST_OVER = 3'd5
    } state_t;

    localparam logic [DATAWIDTH_NIVEL-1:0] LEVEL_FIRST = DATAWIDTH_NIVEL'(1);
    localparam logic [DATAWIDTH_NIVEL-1:0] LEVEL_LAST  = DATAWIDTH_NIVEL'(MAX_LEVEL);
    localparam logic [LIVES_WIDTH-1:0]     LIVES_FULL  = LIVES_WIDTH'(NUM_LIVES);
    localparam logic [LIVES_WIDTH-1:0]     LIVES_ONE   = LIVES_WIDTH'(1);
    localparam logic [HOLD_WIDTH-1:0]      HOLD_LAST   = HOLD_WIDTH'(HOLD_CYCLES - 1);

    state_t                     state_reg, state_next;
    logic [DATAWIDTH_NIVEL-1:0] level_reg, level_next;
    logic [LIVES_WIDTH-1:0]     lives_reg, lives_next;
    logic [HOLD_WIDTH-1:0]      hold_reg, hold_next;
    logic [DATAWIDTH_NIVEL-1:0] nvl_reg, nvl_next;
    logic                       cn_reg, cn_next;
    logic                       win_reg, win_next;
    logic                       over_reg, over_next;

    always_ff @(posedge LVLSEQ_CLOCK) begin
        if (LVLSEQ_RESET) begin
            state_reg <= ST_IDLE;
            level_reg <= LEVEL_FIRST;
            lives_reg <= '0;
            hold_reg  <= '0;
            nvl_reg   <= '0;
            cn_reg    <= 1'b0;
            win_reg   <= 1'b0;
            over_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            level_reg <= level_next;
            lives_reg <= lives_next;
            hold_reg  <= hold_next;
            nvl_reg   <= nvl_next;
            cn_reg    <= cn_next;
            win_reg   <= win_next;
            over_reg  <= over_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        lives_next = lives_reg;
        hold_next  = hold_reg;

        case (state_reg)
            ST_IDLE, ST_WIN, ST_OVER: begin
                if (bus.LVLSEQ_START_IN) begin
                    state_next = ST_LOAD;
                    level_next = LEVEL_FIRST;
                    lives_next = LIVES_FULL;
                end
            end
            ST_LOAD: state_next = ST_RUN;
            ST_RUN: begin
                // Collision takes priority over a simultaneous goal
                if (bus.LVLSEQ_COLLISION_IN) begin
                    if (lives_reg > LIVES_ONE) begin
                        state_next = ST_HOLD;
                        lives_next = lives_reg - LIVES_ONE;
                        hold_next  = '0;
                    end else begin
                        state_next = ST_OVER;
                        lives_next = '0;
                    end
                end else if (bus.LVLSEQ_GOAL_IN) begin
                    if (level_reg < LEVEL_LAST) begin
                        state_next = ST_HOLD;
                        level_next = level_reg + LEVEL_FIRST;
                        hold_next  = '0;
                    end else begin
                        state_next = ST_WIN;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_reg == HOLD_LAST) begin
                    state_next = ST_LOAD;
                    hold_next  = '0;
                end else begin
                    hold_next = hold_reg + HOLD_WIDTH'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                hold_next  = '0;
            end
        endcase

        // Outputs are registered from the next-state view so they line up with STATE_OUT
        nvl_next  = (state_next == ST_LOAD || state_next == ST_RUN) ? level_next : '0;
        cn_next   = (state_next == ST_LOAD);
        win_next  = (state_next == ST_WIN);
        over_next = (state_next == ST_OVER);
    end

    assign bus.LVLSEQ_NVL_OUT      = nvl_reg;
    assign bus.LVLSEQ_CN_OUT       = cn_reg;
    assign bus.LVLSEQ_LIVES_OUT    = lives_reg;
    assign bus.LVLSEQ_WIN_OUT      = win_reg;
    assign bus.LVLSEQ_GAMEOVER_OUT = over_reg;
    assign bus.LVLSEQ_STATE_OUT    = state_reg;

endmodule

// File: tb/tb_lane_level_sequencer.sv
// Directed bench for lane_level_sequencer: walks start, level-up, life loss,
// win, game-over, ignored inputs and mid-hold reset with hand-computed expectations.
module tb_lane_level_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    lane_level_sequencer_if #(.DATAWIDTH_NIVEL(2), .LIVES_WIDTH(2)) bus ();

    lane_level_sequencer #(
        .DATAWIDTH_NIVEL(2),
        .MAX_LEVEL      (3),
        .NUM_LIVES      (3),
        .LIVES_WIDTH    (2),
        .HOLD_CYCLES    (8),
        .HOLD_WIDTH     (4)
    ) dut (
        .LVLSEQ_CLOCK(clk),
        .LVLSEQ_RESET(rst),
        .bus         (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Full output vector check; one line per transaction
    task automatic chk_all(input string tag, input int st, input int nvl, input int cn,
                           input int lives, input int win, input int over);
        $display("%-14s state=%0d nvl=%0d cn=%0d lives=%0d win=%0d over=%0d", tag,
                 bus.LVLSEQ_STATE_OUT, bus.LVLSEQ_NVL_OUT, bus.LVLSEQ_CN_OUT,
                 bus.LVLSEQ_LIVES_OUT, bus.LVLSEQ_WIN_OUT, bus.LVLSEQ_GAMEOVER_OUT);
        chk({tag, ".state"}, int'(bus.LVLSEQ_STATE_OUT), st);
        chk({tag, ".nvl"},   int'(bus.LVLSEQ_NVL_OUT), nvl);
        chk({tag, ".cn"},    int'(bus.LVLSEQ_CN_OUT), cn);
        chk({tag, ".lives"}, int'(bus.LVLSEQ_LIVES_OUT), lives);
        chk({tag, ".win"},   int'(bus.LVLSEQ_WIN_OUT), win);
        chk({tag, ".over"},  int'(bus.LVLSEQ_GAMEOVER_OUT), over);
    endtask

    task automatic pulse(input bit s, input bit g, input bit c);
        bus.LVLSEQ_START_IN     = s;
        bus.LVLSEQ_GOAL_IN      = g;
        bus.LVLSEQ_COLLISION_IN = c;
        tick();
        bus.LVLSEQ_START_IN     = 1'b0;
        bus.LVLSEQ_GOAL_IN      = 1'b0;
        bus.LVLSEQ_COLLISION_IN = 1'b0;
    endtask

    // Called right after HOLD is entered: 7 more HOLD clocks, then LOAD, then RUN
    task automatic run_hold(input string tag, input int lvl, input int lives);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_all({tag, ".hold"}, 3, 0, 0, lives, 0, 0);
        end
        tick();
        chk_all({tag, ".load"}, 1, lvl, 1, lives, 0, 0);
        tick();
        chk_all({tag, ".run"}, 2, lvl, 0, lives, 0, 0);
    endtask

    initial begin
        bus.LVLSEQ_START_IN     = 1'b0;
        bus.LVLSEQ_GOAL_IN      = 1'b0;
        bus.LVLSEQ_COLLISION_IN = 1'b0;
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        chk_all("idle", 0, 0, 0, 0, 0, 0);

        // Start: one LOAD clock then RUN at level 1
        pulse(1, 0, 0);
        chk_all("t1.load", 1, 1, 1, 3, 0, 0);
        tick();
        chk_all("t1.run", 2, 1, 0, 3, 0, 0);
        pulse(1, 0, 0);
        chk_all("t1.start_run", 2, 1, 0, 3, 0, 0);

        // Goal at level 1 -> 8-clock freeze -> level 2
        pulse(0, 1, 0);
        chk_all("t2.goal", 3, 0, 0, 3, 0, 0);
        run_hold("t2", 2, 3);

        // Goal+collision together at L2: collision wins; goal/start in HOLD ignored
        pulse(0, 1, 1);
        chk_all("t5.both", 3, 0, 0, 2, 0, 0);
        tick();
        tick();
        pulse(0, 1, 0);
        chk_all("t5.goal_hold", 3, 0, 0, 2, 0, 0);
        pulse(1, 0, 0);
        chk_all("t5.start_hold", 3, 0, 0, 2, 0, 0);
        for (int i = 5; i < 8; i++) begin
            tick();
            chk_all("t5.hold", 3, 0, 0, 2, 0, 0);
        end
        tick();
        chk_all("t5.load", 1, 2, 1, 2, 0, 0);
        tick();
        chk_all("t5.run", 2, 2, 0, 2, 0, 0);

        // Collisions drain lives to game over
        pulse(0, 0, 1);
        chk_all("t3.coll1", 3, 0, 0, 1, 0, 0);
        run_hold("t3", 2, 1);
        pulse(0, 0, 1);
        chk_all("t3.over", 5, 0, 0, 0, 0, 1);
        pulse(0, 1, 1);
        chk_all("t3.over_ign", 5, 0, 0, 0, 0, 1);

        // Restart, climb three levels to WIN
        pulse(1, 0, 0);
        chk_all("t4.load", 1, 1, 1, 3, 0, 0);
        tick();
        chk_all("t4.run", 2, 1, 0, 3, 0, 0);
        pulse(0, 1, 0);
        chk_all("t4.goal1", 3, 0, 0, 3, 0, 0);
        run_hold("t4a", 2, 3);
        pulse(0, 1, 0);
        chk_all("t4.goal2", 3, 0, 0, 3, 0, 0);
        run_hold("t4b", 3, 3);
        pulse(0, 1, 0);
        chk_all("t4.win", 4, 0, 0, 3, 1, 0);
        pulse(0, 0, 1);
        chk_all("t4.win_ign", 4, 0, 0, 3, 1, 0);
        pulse(1, 0, 0);
        chk_all("t4.restart", 1, 1, 1, 3, 0, 0);
        tick();
        chk_all("t4.run1", 2, 1, 0, 3, 0, 0);

        // Reset in the middle of HOLD (count=4): straight to IDLE, no strobe
        pulse(0, 1, 0);
        chk_all("t6.goal", 3, 0, 0, 3, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        chk_all("t6.reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        chk_all("t6.idle", 0, 0, 0, 0, 0, 0);
        pulse(1, 0, 0);
        chk_all("t6.load", 1, 1, 1, 3, 0, 0);
        pulse(0, 1, 0);
        chk_all("t6.goal_load", 2, 1, 0, 3, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
